// File: rtl/l1_pkg.sv
// l1_pkg: shared defaults and types for the L1 stream pointer controller.
//   DEF_NSTRMS    default number of streams
//   DEF_NPORTS    default number of read ports
//   DEF_PTR_WIDTH default read-pointer width
//   occ_w()       occupancy counter width for a given pointer width
//   strm_rec_t    per-stream {ptr, occ} record at the default widths
package l1_pkg;

    localparam int DEF_NSTRMS    = 64;
    localparam int DEF_NPORTS    = 8;
    localparam int DEF_PTR_WIDTH = 6;

    // Occupancy must represent 0..2**pw inclusive, hence one extra bit.
    function automatic int occ_w(input int pw);
        return pw + 1;
    endfunction

    typedef struct packed {
        logic [DEF_PTR_WIDTH-1:0] ptr;
        logic [DEF_PTR_WIDTH:0]   occ;
    } strm_rec_t;

endpackage

// File: rtl/l1_strm_slot.sv
// l1_strm_slot: read pointer and occupancy for one stream.
//   clk, reset  clock, synchronous active-high reset
//   req_v_i     request valid from each read port for this stream
//   req_r_o     grant to each read port (lowest ports first, up to occ)
//   wr_i        one accepted write to this stream this cycle
//   srst_i      stream reset targets this stream this cycle
//   ptr_o       registered read pointer
//   occ_o       registered occupancy
//   full_o      occupancy equals stream depth
module l1_strm_slot
    import l1_pkg::*;
#(
    parameter int nports    = DEF_NPORTS,
    parameter int ptr_width = DEF_PTR_WIDTH,
    parameter int occ_width = occ_w(ptr_width)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [nports-1:0]    req_v_i,
    output logic [nports-1:0]    req_r_o,
    input  logic                 wr_i,
    input  logic                 srst_i,
    output logic [ptr_width-1:0] ptr_o,
    output logic [occ_width-1:0] occ_o,
    output logic                 full_o
);

    localparam int CNT_W = $clog2(nports + 1);
    // Compare width wide enough for both a request count and an occupancy.
    localparam int CMP_W = (CNT_W > occ_width) ? CNT_W : occ_width;
    localparam logic [occ_width-1:0] OCC_FULL = {1'b1, {ptr_width{1'b0}}};

    logic [ptr_width-1:0] ptr_q, ptr_d;
    logic [occ_width-1:0] occ_q, occ_d;
    logic [CMP_W-1:0]     n_s;
    logic [CMP_W-1:0]     rd_s;

    // Prefix-count requesters and grant while the running count fits in occ.
    always_comb begin
        n_s     = {CMP_W{1'b0}};
        rd_s    = {CMP_W{1'b0}};
        req_r_o = {nports{1'b0}};
        for (int p = 0; p < nports; p++) begin
            if (req_v_i[p]) begin
                n_s = n_s + CMP_W'(1);
                if ((n_s <= CMP_W'(occ_q)) && !srst_i && !reset) begin
                    req_r_o[p] = 1'b1;
                    rd_s       = rd_s + CMP_W'(1);
                end else begin
                    req_r_o[p] = 1'b0;
                end
            end else begin
                req_r_o[p] = 1'b0;
            end
        end
    end

    // Next state: stream reset overrides; otherwise advance by reads, adjust occ.
    always_comb begin
        if (srst_i) begin
            ptr_d = {ptr_width{1'b0}};
            occ_d = {occ_width{1'b0}};
        end else begin
            // rd_s <= occ_q <= 2**ptr_width, so narrowing is lossless for occ.
            ptr_d = ptr_q + ptr_width'(rd_s);
            occ_d = occ_q + {{(occ_width-1){1'b0}}, wr_i} - occ_width'(rd_s);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= {ptr_width{1'b0}};
            occ_q <= {occ_width{1'b0}};
        end else begin
            ptr_q <= ptr_d;
            occ_q <= occ_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign occ_o  = occ_q;
    assign full_o = (occ_q == OCC_FULL);

endmodule

// File: rtl/l1_strm_ptr_ctrl.sv
// l1_strm_ptr_ctrl: per-stream read pointer / occupancy tracker.
// Optional feature macro: L1_PTR_STALL_CNT_EN (adds o_stall_cnt).
//   clk, reset     clock, synchronous active-high reset
//   i_req_v/r      port-major request valid/ready (bit p*nstrms+s)
//   i_wr_v/r/sid   single-entry write notification
//   i_srst_v/r/sid per-stream reset request (always accepted)
//   o_ptrs         registered read pointers, stream s at [s*ptr_width +: ptr_width]
//   o_occ          registered occupancies, stream s at [s*occ_width +: occ_width]
//   o_stall_cnt    saturating count of cycles with a refused request (macro only)
module l1_strm_ptr_ctrl
    import l1_pkg::*;
#(
    parameter int nstrms    = DEF_NSTRMS,
    parameter int sid_width = $clog2(nstrms),
    parameter int nports    = DEF_NPORTS,
    parameter int ptr_width = DEF_PTR_WIDTH,
    parameter int occ_width = occ_w(ptr_width)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [nports*nstrms-1:0]    i_req_v,
    output logic [nports*nstrms-1:0]    i_req_r,
    input  logic                        i_wr_v,
    output logic                        i_wr_r,
    input  logic [sid_width-1:0]        i_wr_sid,
    input  logic                        i_srst_v,
    output logic                        i_srst_r,
    input  logic [sid_width-1:0]        i_srst_sid,
    output logic [nstrms*ptr_width-1:0] o_ptrs,
`ifdef L1_PTR_STALL_CNT_EN
    output logic [nstrms*occ_width-1:0] o_occ,
    output logic [31:0]                 o_stall_cnt
`else
    output logic [nstrms*occ_width-1:0] o_occ
`endif
);

    logic [nstrms-1:0] full_s;
    logic [nstrms-1:0] wr_hit_s;
    logic [nstrms-1:0] srst_hit_s;

    assign i_srst_r = 1'b1;

    // Write acceptance looks at registered occupancy only, so it stays
    // conservative when a same-cycle read would have made room.
    assign i_wr_r = reset ? 1'b1
                          : (~full_s[i_wr_sid] & ~(i_srst_v & (i_srst_sid == i_wr_sid)));

    for (genvar s = 0; s < nstrms; s++) begin : g_slot
        logic [nports-1:0] col_v_s;
        logic [nports-1:0] col_r_s;

        // Port-major bus to per-stream column and back.
        for (genvar p = 0; p < nports; p++) begin : g_port
            assign col_v_s[p]            = i_req_v[p*nstrms+s];
            assign i_req_r[p*nstrms+s]   = col_r_s[p];
        end

        assign wr_hit_s[s]   = i_wr_v & i_wr_r & (i_wr_sid == sid_width'(s));
        assign srst_hit_s[s] = i_srst_v & (i_srst_sid == sid_width'(s));

        l1_strm_slot #(
            .nports    (nports),
            .ptr_width (ptr_width),
            .occ_width (occ_width)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .req_v_i (col_v_s),
            .req_r_o (col_r_s),
            .wr_i    (wr_hit_s[s]),
            .srst_i  (srst_hit_s[s]),
            .ptr_o   (o_ptrs[s*ptr_width +: ptr_width]),
            .occ_o   (o_occ[s*occ_width +: occ_width]),
            .full_o  (full_s[s])
        );
    end

`ifdef L1_PTR_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_s;

    assign stall_s = |(i_req_v & ~i_req_r);

    // Saturating increment on any refused request.
    always_comb begin
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; stream resets leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_l1_strm_ptr_ctrl.sv
module tb_l1_strm_ptr_ctrl;

    localparam int NS  = 8;
    localparam int NP  = 4;
    localparam int PW  = 3;
    localparam int OW  = 4;
    localparam int SW  = 3;

    logic              clk;
    logic              reset;
    logic [NP*NS-1:0]  i_req_v;
    logic [NP*NS-1:0]  i_req_r;
    logic              i_wr_v;
    logic              i_wr_r;
    logic [SW-1:0]     i_wr_sid;
    logic              i_srst_v;
    logic              i_srst_r;
    logic [SW-1:0]     i_srst_sid;
    logic [NS*PW-1:0]  o_ptrs;
    logic [NS*OW-1:0]  o_occ;
`ifdef L1_PTR_STALL_CNT_EN
    logic [31:0]       o_stall_cnt;
`endif

    int n_checks;
    int n_errors;

    l1_strm_ptr_ctrl #(
        .nstrms    (NS),
        .sid_width (SW),
        .nports    (NP),
        .ptr_width (PW),
        .occ_width (OW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_wr_v     (i_wr_v),
        .i_wr_r     (i_wr_r),
        .i_wr_sid   (i_wr_sid),
        .i_srst_v   (i_srst_v),
        .i_srst_r   (i_srst_r),
        .i_srst_sid (i_srst_sid),
        .o_ptrs     (o_ptrs),
`ifdef L1_PTR_STALL_CNT_EN
        .o_occ      (o_occ),
        .o_stall_cnt(o_stall_cnt)
`else
        .o_occ      (o_occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] req_v;
        logic        wr_v;
        logic [2:0]  wr_sid;
        logic        srst_v;
        logic [2:0]  srst_sid;
        logic [31:0] exp_r;
        logic        exp_wr_r;
        int          chk_sid;
        logic [2:0]  exp_ptr;
        logic [3:0]  exp_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rq(input int p, input int s);
        logic [31:0] one;
        one = 32'd1;
        return one << (p*NS + s);
    endfunction

    function automatic vec_t mk(input logic [31:0] rv, input logic wv, input logic [2:0] ws,
                                input logic sv, input logic [2:0] ss, input logic [31:0] er,
                                input logic ewr, input int cs, input logic [2:0] ep,
                                input logic [3:0] eo);
        vec_t v;
        v.req_v = rv; v.wr_v = wv; v.wr_sid = ws; v.srst_v = sv; v.srst_sid = ss;
        v.exp_r = er; v.exp_wr_r = ewr; v.chk_sid = cs; v.exp_ptr = ep; v.exp_occ = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        i_req_v    = v.req_v;
        i_wr_v     = v.wr_v;
        i_wr_sid   = v.wr_sid;
        i_srst_v   = v.srst_v;
        i_srst_sid = v.srst_sid;
        #1;
        chk($sformatf("v%0d req_r", idx), 64'(i_req_r), 64'(v.exp_r));
        chk($sformatf("v%0d wr_r", idx), 64'(i_wr_r), 64'(v.exp_wr_r));
        chk($sformatf("v%0d srst_r", idx), 64'(i_srst_r), 64'd1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ptr[%0d]", idx, v.chk_sid),
            64'(o_ptrs[v.chk_sid*PW +: PW]), 64'(v.exp_ptr));
        chk($sformatf("v%0d occ[%0d]", idx, v.chk_sid),
            64'(o_occ[v.chk_sid*OW +: OW]), 64'(v.exp_occ));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        i_req_v    = 32'd0;
        i_wr_v     = 1'b0;
        i_wr_sid   = 3'd0;
        i_srst_v   = 1'b0;
        i_srst_sid = 3'd0;

        // Stream 5: three writes, then all four ports request it.
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(32'd0, 1'b1, 3'd5, 1'b0, 3'd0, 32'd0, 1'b1, 5, 3'd0, 4'(i)));
        tbl.push_back(mk(rq(0,5)|rq(1,5)|rq(2,5)|rq(3,5), 1'b0, 3'd0, 1'b0, 3'd0,
                         rq(0,5)|rq(1,5)|rq(2,5), 1'b1, 5, 3'd3, 4'd0));
        // Stream 2: fill to depth, refused ninth write, then drain with wrap.
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(32'd0, 1'b1, 3'd2, 1'b0, 3'd0, 32'd0, 1'b1, 2, 3'd0, 4'(i)));
        tbl.push_back(mk(32'd0, 1'b1, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 2, 3'd0, 4'd8));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(rq(0,2), 1'b0, 3'd0, 1'b0, 3'd0, rq(0,2), 1'b1, 2,
                             3'(i), 4'(8-i)));
        tbl.push_back(mk(rq(0,2), 1'b0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 2, 3'd0, 4'd0));
        // Stream 1: occ 2, then write plus two grants in one cycle.
        tbl.push_back(mk(32'd0, 1'b1, 3'd1, 1'b0, 3'd0, 32'd0, 1'b1, 1, 3'd0, 4'd1));
        tbl.push_back(mk(32'd0, 1'b1, 3'd1, 1'b0, 3'd0, 32'd0, 1'b1, 1, 3'd0, 4'd2));
        tbl.push_back(mk(rq(1,1)|rq(3,1), 1'b1, 3'd1, 1'b0, 3'd0, rq(1,1)|rq(3,1), 1'b1,
                         1, 3'd2, 4'd1));
        // Stream reset of 4 alongside a grant to stream 6.
        tbl.push_back(mk(32'd0, 1'b1, 3'd6, 1'b0, 3'd0, 32'd0, 1'b1, 6, 3'd0, 4'd1));
        tbl.push_back(mk(32'd0, 1'b1, 3'd4, 1'b0, 3'd0, 32'd0, 1'b1, 4, 3'd0, 4'd1));
        tbl.push_back(mk(32'd0, 1'b1, 3'd4, 1'b0, 3'd0, 32'd0, 1'b1, 4, 3'd0, 4'd2));
        tbl.push_back(mk(rq(0,4)|rq(1,4)|rq(2,6), 1'b0, 3'd0, 1'b1, 3'd4, rq(2,6), 1'b1,
                         4, 3'd0, 4'd0));
        tbl.push_back(mk(32'd0, 1'b0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 6, 3'd1, 4'd0));
        // Write to the stream being reset is refused.
        tbl.push_back(mk(32'd0, 1'b1, 3'd3, 1'b1, 3'd3, 32'd0, 1'b0, 3, 3'd0, 4'd0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset ptrs", 64'(o_ptrs), 64'd0);
        chk("reset occ", 64'(o_occ), 64'd0);
        chk("reset req_r", 64'(i_req_r), 64'd0);
        chk("reset wr_r", 64'(i_wr_r), 64'd1);
        chk("reset srst_r", 64'(i_srst_r), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Global reset in the middle of a burst to stream 7.
        @(negedge clk);
        i_srst_v = 1'b0;
        i_req_v  = 32'd0;
        i_wr_v   = 1'b1;
        i_wr_sid = 3'd7;
        @(negedge clk);
        @(negedge clk);
        i_wr_v  = 1'b0;
        i_req_v = rq(0,7) | rq(1,7);
        #1;
        chk("burst req_r", 64'(i_req_r), 64'(rq(0,7) | rq(1,7)));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("greset ptrs", 64'(o_ptrs), 64'd0);
        chk("greset occ", 64'(o_occ), 64'd0);
        chk("greset req_r", 64'(i_req_r), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post reset req_r", 64'(i_req_r), 64'd0);
        i_req_v = 32'd0;

`ifdef L1_PTR_STALL_CNT_EN
        @(negedge clk);
        i_req_v = rq(0,3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        i_req_v = 32'd0;
        #1;
        chk("stall_cnt", 64'(o_stall_cnt), 64'd5);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l1_strm_ptr_ctrl.md
Name: l1_strm_ptr_ctrl

Overview:
- Per-stream read-pointer and occupancy tracker for the L1 multi-stream buffer.
- Sits directly downstream of the per-port L1 read request stage. Consumes the per-stream request valids that the read ports emit, and grants or refuses them by occupancy.
- Advances each stream's read pointer by the number of grants and drives the pointer array back to the read ports, where it forms BRAM addresses.
- Also accepts L1 write notifications and per-stream reset requests.

Parameters:
- nstrms, 64, number of streams.
- sid_width, $clog2(nstrms), stream id width.
- nports, 8, number of read ports.
- ptr_width, 6, read-pointer width; per-stream depth is 2**ptr_width entries.
- occ_width, ptr_width+1, occupancy counter width (range 0..2**ptr_width).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req_v  in  nports*nstrms  request valids, port-major: bit p*nstrms+s = port p requests stream s.
- i_req_r  out  nports*nstrms  request readies, same layout.
- i_wr_v  in  1  one entry written to stream i_wr_sid.
- i_wr_r  out  1  write accepted.
- i_wr_sid  in  sid_width  written stream id.
- i_srst_v  in  1  stream reset request.
- i_srst_r  out  1  always 1 (reset is always accepted).
- i_srst_sid  in  sid_width  stream to reset.
- o_ptrs  out  nstrms*ptr_width  registered read pointer per stream; stream s at bits [(s+1)*ptr_width-1 : s*ptr_width].
- o_occ  out  nstrms*occ_width  registered occupancy per stream.

Behaviour:
- Reset: all pointers 0, all occupancies 0; i_req_r all 0, i_wr_r 1, i_srst_r 1.
- Grant rule per stream s, combinational on registered occ[s] (same-cycle writes are not counted):
  - n_p = number of ports q ≤ p with i_req_v[q][s] set.
  - i_req_r[p][s] = i_req_v[p][s] & (n_p ≤ occ[s]) & ~(i_srst_v & i_srst_sid==s).
  - Lower port ids win; grants are always a prefix of the requesting ports.
  - Ready depends on valid (allowed here). A requester must hold valid until ready; a refused request retries the next cycle.
- Read count: rd[s] = popcount of granted bits for s (0..nports).
- Write acceptance: i_wr_r = (occ[i_wr_sid] != 2**ptr_width) & ~(i_srst_v & i_srst_sid==i_wr_sid). Computed on registered occupancy; conservative when full even if a same-cycle read frees space. wr[s] = i_wr_v & i_wr_r & (i_wr_sid==s).
- Next state per stream s:
  - If stream reset targets s: ptr ← 0, occ ← 0. Reset overrides reads and writes to s in the same cycle.
  - Otherwise: ptr ← ptr + rd[s] mod 2**ptr_width (wrap-around is natural), and occ ← occ + wr[s] − rd[s].
  - occ never underflows (grant rule) and never overflows (write rule).
- Latency: updated pointer and occupancy appear on o_ptrs / o_occ the cycle after the grant, write or reset. The read ports rely on this one-cycle update so that back-to-back same-stream reads see the advanced pointer.
- Simultaneous events:
  - Write and grants to the same stream in one cycle: both applied.
  - Stream reset to stream A with grants to stream B: B unaffected.
  - nports > occ: only the lowest occ requesting ports are granted.
- Global reset mid-operation: all state returns to reset values on the next edge; in-flight requests are dropped.

Optional Feature:
- Macro: L1_PTR_STALL_CNT_EN.
- With the macro: adds output o_stall_cnt [31:0]. It increments, saturating at 2^32−1, in every cycle where any i_req_v bit is set with its i_req_r bit clear. It clears on reset and is unaffected by stream reset.
- Without the macro: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package l1_pkg:
  - Defaults for nstrms, nports, ptr_width.
  - Helper function for occupancy width.
  - A typedef for the per-stream {ptr, occ} record.
- Sub-module l1_strm_slot, instantiated nstrms times. Per stream it:
  - takes the nports request valid column;
  - holds the ptr/occ register;
  - computes prefix counts and grants, and applies write/reset.
- The top level handles the port-major transpose, write/reset sid decode, and optional stall counter.

Test Plan:
- Config ptr_width=3, nports=4. Write 3 entries to stream 5, then ports 0..3 all request stream 5 → ports 0..2 ready, port 3 not ready; next cycle ptr[5]=3, occ[5]=0.
- Write 8 entries to stream 2 → i_wr_r drops after the 8th write (occ[2]=8). Eight single-port reads → ptr[2] wraps from 7 to 0, occ[2]=0.
- Same cycle: write to stream 1 (occ 2) plus 2 grants to stream 1 → next cycle occ[1]=1, ptr advances by 2.
- Stream reset of stream 4 while ports 0,1 request stream 4 and port 2 requests stream 6 (occ 1) → stream 4 grants 0; ptr[4]=0, occ[4]=0; stream 6 granted, ptr[6]+1.
- Global reset asserted mid-burst → next cycle all o_ptrs=0, o_occ=0, all i_req_r=0.
- With L1_PTR_STALL_CNT_EN: 5 cycles of a request to an empty stream → o_stall_cnt=5.
